pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the posit datapath (fraction alignment/add and exponent arithmetic). The operand word is split into BLOCK-bit lookahead groups, with one group resolved per pipeline stage and the group carry registered between stages. It uses a valid/ready handshake with whole-pipe stall and carries a sideband tag. It produces sum, carry-out and signed-overflow.

---
 rtl/ppu_arith_pkg.sv | 13 +
 rtl/pipelined_cla_adder_if.sv | 24 ++
 rtl/pipelined_cla_adder_cla_block.sv | 30 +++
 rtl/pipelined_cla_adder.sv | 83 ++++++++
 tb/tb_pipelined_cla_adder.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/ppu_arith_pkg.sv
// ppu_arith_pkg: shared sizing helpers and stage record for the posit arithmetic datapath
package ppu_arith_pkg;
  function automatic int nblk(input int width, input int block);
    return width / block;
  endfunction
  function automatic bit cfg_ok(input int width, input int block);
    return block >= 1 && width % block == 0;
  endfunction
  typedef struct packed {
    logic valid;
    logic carry;
  } stage_t;
endpackage

// File: rtl/pipelined_cla_adder_if.sv
// pipelined_cla_adder_if: operand/result valid-ready bundle for the pipelined adder
interface pipelined_cla_adder_if #(parameter int WIDTH = 32, parameter int TAG_W = 4);
  logic             i_valid;
  logic             o_ready;
  logic [WIDTH-1:0] i_a;
  logic [WIDTH-1:0] i_b;
  logic             i_cin;
  logic             i_sub;
  logic [TAG_W-1:0] i_tag;
  logic             o_valid;
  logic             i_ready;
  logic [WIDTH-1:0] o_sum;
  logic             o_cout;
  logic             o_ovf;
  logic [TAG_W-1:0] o_tag;
  modport master (
    output i_valid, i_a, i_b, i_cin, i_sub, i_tag, i_ready,
    input  o_ready, o_valid, o_sum, o_cout, o_ovf, o_tag
  );
  modport slave (
    input  i_valid, i_a, i_b, i_cin, i_sub, i_tag, i_ready,
    output o_ready, o_valid, o_sum, o_cout, o_ovf, o_tag
  );
endinterface

// File: rtl/pipelined_cla_adder_cla_block.sv
// cla_block: BLOCK-bit carry-lookahead group with carry-out and carry into its MSB
module cla_block
  import ppu_arith_pkg::*;
#(
  parameter int BLOCK = 8
) (
  input  logic [BLOCK-1:0] a,
  input  logic [BLOCK-1:0] b,
  input  logic             cin,
  output logic [BLOCK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);
  logic [BLOCK-1:0] g, p;
  logic [BLOCK:0]   c;
  assign g = a & b;
  assign p = a ^ b;
  // each carry is expanded independently from g/p/cin, not chained off its neighbour
  always_comb begin
    c    = '0;
    c[0] = cin;
    for (int i = 0; i < BLOCK; i++) begin
      c[i+1] = cin;
      for (int j = 0; j <= i; j++) c[i+1] = g[j] | (p[j] & c[i+1]);
    end
  end
  assign sum  = p ^ c[BLOCK-1:0];
  assign cout = c[BLOCK];
  assign cmsb = c[BLOCK-1];
endmodule

// File: rtl/pipelined_cla_adder.sv
// pipelined_cla_adder: one lookahead group per stage adder/subtractor with whole-pipe stall
module pipelined_cla_adder
  import ppu_arith_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int BLOCK = 8,
  parameter int TAG_W = 4
) (
  input logic                 i_clk,
  input logic                 i_rst,
  pipelined_cla_adder_if.slave bus
);
  localparam int NB = nblk(WIDTH, BLOCK);
  if (!cfg_ok(WIDTH, BLOCK)) begin : g_cfg
    $error("pipelined_cla_adder: WIDTH must be a nonzero multiple of BLOCK");
  end
  logic             adv;
  logic [WIDTH-1:0] b_x;
  logic             c0;
  assign adv         = ~bus.o_valid | bus.i_ready;
  assign bus.o_ready = adv;
  assign b_x         = bus.i_sub ? ~bus.i_b : bus.i_b;
  assign c0          = bus.i_sub | bus.i_cin;
  for (genvar k = 0; k < NB; k++) begin : g
    logic [WIDTH-1:0]       a_in, b_in, s_in, a_d, b_d, s_d;
    logic                   v_in, c_in, co, cm;
    logic [TAG_W-1:0]       t_in;
    logic [BLOCK-1:0]       s;
    logic [WIDTH+BLOCK-1:0] cat;
    stage_t                 st_q;
    logic [TAG_W-1:0]       t_q;
    logic [WIDTH-1:0]       a_q, b_q, s_q;
    logic                   ov_q;
    if (k == 0) begin : h
      assign a_in = bus.i_a;
      assign b_in = b_x;
      assign s_in = '0;
      assign v_in = bus.i_valid;
      assign c_in = c0;
      assign t_in = bus.i_tag;
    end else begin : h
      assign a_in = g[k-1].a_q;
      assign b_in = g[k-1].b_q;
      assign s_in = g[k-1].s_q;
      assign v_in = g[k-1].st_q.valid;
      assign c_in = g[k-1].st_q.carry;
      assign t_in = g[k-1].t_q;
    end
    cla_block #(.BLOCK(BLOCK)) u_cla (
      .a(a_in[BLOCK-1:0]), .b(b_in[BLOCK-1:0]), .cin(c_in),
      .sum(s), .cout(co), .cmsb(cm)
    );
    // operands shift down so the next group is always at bit 0; sum bits shift in from the top
    assign cat = {s, s_in};
    assign s_d = cat[WIDTH+BLOCK-1:BLOCK];
    assign a_d = a_in >> BLOCK;
    assign b_d = b_in >> BLOCK;
    always_ff @(posedge i_clk or posedge i_rst)
      if (i_rst) begin
        st_q <= '0;
        t_q  <= '0;
        a_q  <= '0;
        b_q  <= '0;
        s_q  <= '0;
        ov_q <= 1'b0;
      end else if (adv) begin
        st_q.valid <= v_in;
        if (v_in) begin
          st_q.carry <= co;
          t_q        <= t_in;
          a_q        <= a_d;
          b_q        <= b_d;
          s_q        <= s_d;
          ov_q       <= cm ^ co;
        end
      end
  end
  assign bus.o_valid = g[NB-1].st_q.valid;
  assign bus.o_sum   = g[NB-1].s_q;
  assign bus.o_cout  = g[NB-1].st_q.carry;
  assign bus.o_ovf   = g[NB-1].ov_q;
  assign bus.o_tag   = g[NB-1].t_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb_pipelined_cla_adder: randomized scoreboard bench against an integer-arithmetic reference
module tb_pipelined_cla_adder;
  localparam int W = 16, BK = 4, TW = 4, NB = W / BK;
  typedef struct {
    logic [W-1:0]  sum;
    logic          cout;
    logic          ovf;
    logic [TW-1:0] tag;
    int            acc;
    bit            lat;
  } exp_t;
  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;
  pipelined_cla_adder_if #(.WIDTH(W), .TAG_W(TW)) bus ();
  pipelined_cla_adder #(.WIDTH(W), .BLOCK(BK), .TAG_W(TW)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
  exp_t scb[$];
  int checks = 0, passed = 0, cyc = 0, ready_mode = 0;
  always @(posedge clk) cyc++;
  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask
  function automatic exp_t model(input logic [W-1:0] a, b, input logic cin, sub, input logic [TW-1:0] tag);
    exp_t e;
    int sa, sb, ua, ub, ur, sr;
    sa = $signed(a); sb = $signed(b); ua = a; ub = b;
    if (sub) begin
      ur = ua - ub; sr = sa - sb; e.cout = ua >= ub;
    end else begin
      ur = ua + ub + cin; sr = sa + sb + cin; e.cout = ur > 32'hFFFF;
    end
    e.sum = ur[W-1:0];
    e.ovf = sr > 32767 || sr < -32768;
    e.tag = tag;
    e.acc = 0;
    e.lat = 0;
    return e;
  endfunction
  task automatic push(input logic [W-1:0] a, b, input logic cin, sub, input logic [TW-1:0] tag, input bit lat);
    exp_t e;
    e = model(a, b, cin, sub, tag);
    e.acc = cyc;
    e.lat = lat;
    scb.push_back(e);
  endtask
  // called at posedge+1; returns at posedge+1 after the beat is taken
  task automatic send(input logic [W-1:0] a, b, input logic cin, sub, input logic [TW-1:0] tag, input bit lat);
    int n = 0;
    bus.i_valid = 1'b1; bus.i_a = a; bus.i_b = b; bus.i_cin = cin; bus.i_sub = sub; bus.i_tag = tag;
    @(negedge clk);
    while (!bus.o_ready && n < 200) begin
      @(posedge clk); #1; @(negedge clk); n++;
    end
    if (!bus.o_ready) chk("accept_timeout", 0, 1);
    else push(a, b, cin, sub, tag, lat);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
  endtask
  task automatic wait_drain();
    int n = 0;
    while ((scb.size() != 0 || bus.o_valid) && n < 200) begin
      @(posedge clk); #1; n++;
    end
    chk("drain_left", scb.size(), 0);
  endtask
  always @(posedge clk) begin
    #1;
    if (ready_mode == 1) bus.i_ready = ~bus.i_ready;
    else if (ready_mode == 2) bus.i_ready = ($urandom_range(0, 3) != 0);
  end
  always @(negedge clk)
    if (!rst && bus.o_valid && bus.i_ready) begin
      if (scb.size() == 0) chk("unexpected_result", 1, 0);
      else begin
        exp_t e;
        e = scb.pop_front();
        chk("sum", bus.o_sum, e.sum);
        chk("cout", bus.o_cout, e.cout);
        chk("ovf", bus.o_ovf, e.ovf);
        chk("tag", bus.o_tag, e.tag);
        if (e.lat) chk("latency", cyc - e.acc, NB);
      end
    end
  logic [W-1:0]  h_sum;
  logic [TW-1:0] h_tag;
  logic          h_cout, h_ovf;
  bit            held = 0;
  always @(negedge clk)
    if (rst) held = 0;
    else begin
      if (held) begin
        chk("hold_valid", bus.o_valid, 1);
        chk("hold_sum", bus.o_sum, h_sum);
        chk("hold_flags", {bus.o_cout, bus.o_ovf}, {h_cout, h_ovf});
        chk("hold_tag", bus.o_tag, h_tag);
      end
      held = bus.o_valid && !bus.i_ready;
      h_sum = bus.o_sum; h_tag = bus.o_tag; h_cout = bus.o_cout; h_ovf = bus.o_ovf;
    end
  initial begin
    int n;
    bus.i_valid = 1'b1; bus.i_a = 16'h1111; bus.i_b = 16'h2222; bus.i_cin = 1'b0;
    bus.i_sub = 1'b0; bus.i_tag = 4'hA; bus.i_ready = 1'b0;
    #1 rst = 1'b1;
    #2;
    chk("rst_valid", bus.o_valid, 0);
    chk("rst_sum", bus.o_sum, 0);
    chk("rst_tag", bus.o_tag, 0);
    chk("rst_ready", bus.o_ready, 1);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid_held", bus.o_valid, 0);
    chk("rst_cout_ovf", {bus.o_cout, bus.o_ovf}, 0);
    bus.i_valid = 1'b0; bus.i_ready = 1'b1; rst = 1'b0;
    // directed add/subtract corners with latency checked
    send(16'hFFFF, 16'h0001, 0, 0, 4'h1, 1);
    send(16'h7FFF, 16'h0001, 0, 0, 4'h2, 1);
    send(16'h1234, 16'h0000, 1, 0, 4'h3, 1);
    send(16'h0005, 16'h0007, 1, 1, 4'h4, 1);
    send(16'h8000, 16'h0001, 1, 1, 4'h5, 1);
    send(16'h8000, 16'h8000, 0, 1, 4'h6, 1);
    send(16'h0000, 16'h8000, 0, 1, 4'h7, 1);
    wait_drain();
    // back-to-back stream under alternating downstream ready
    ready_mode = 1;
    for (int t = 0; t < 8; t++)
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'(t), 0);
    ready_mode = 0;
    bus.i_ready = 1'b1;
    wait_drain();
    // full-pipe stall then release
    bus.i_ready = 1'b0;
    for (int t = 0; t < NB; t++) send(16'($urandom), 16'($urandom), 0, 0, 4'(8 + t), 0);
    bus.i_valid = 1'b1; bus.i_a = 16'hABCD; bus.i_b = 16'h1357; bus.i_cin = 1'b1; bus.i_sub = 1'b0; bus.i_tag = 4'hE;
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      chk("stall_ready", bus.o_ready, 0);
      @(posedge clk); #1;
    end
    bus.i_ready = 1'b1;
    @(negedge clk);
    chk("release_ready", bus.o_ready, 1);
    chk("drain_valid", bus.o_valid, 1);
    push(16'hABCD, 16'h1357, 1, 0, 4'hE, 0);
    @(posedge clk); #1;
    bus.i_valid = 1'b0;
    for (int t = 1; t < NB; t++) begin
      @(negedge clk);
      chk("drain_valid", bus.o_valid, 1);
      @(posedge clk); #1;
    end
    wait_drain();
    // asynchronous reset with beats in flight
    bus.i_ready = 1'b0;
    for (int t = 0; t < 3; t++) send(16'($urandom), 16'($urandom), 0, 1, 4'(t), 0);
    n = 0;
    @(negedge clk);
    while (!bus.o_valid && n < 20) begin @(negedge clk); n++; end
    chk("inflight_valid", bus.o_valid, 1);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_valid", bus.o_valid, 0);
    chk("async_rst_sum", bus.o_sum, 0);
    chk("async_rst_tag", bus.o_tag, 0);
    scb.delete();
    bus.i_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    send(16'h4321, 16'h1234, 0, 1, 4'h9, 1);
    wait_drain();
    // randomized traffic with random backpressure and gaps
    ready_mode = 2;
    for (int t = 0; t < 150; t++) begin
      send(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), 0);
      if ($urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
    ready_mode = 0;
    bus.i_ready = 1'b1;
    wait_drain();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
